// File: rtl/io_channel_bank_pkg.sv
// Shared channel map, status bit positions and outbound FIFO entry type for the IO channel bank.
// Pure declarations: no latency, no flow control.
package io_channel_bank_pkg;

  localparam int CH_W   = 5;
  localparam int DATA_W = 15;

  localparam logic [CH_W-1:0] CH_STATUS    = 5'd0;
  localparam logic [CH_W-1:0] CH_TIMER     = 5'd1;
  localparam logic [CH_W-1:0] CH_OUT_FIRST = 5'd2;
  localparam logic [CH_W-1:0] CH_OUT_LAST  = 5'd15;
  localparam logic [CH_W-1:0] CH_IN_FIRST  = 5'd16;
  localparam logic [CH_W-1:0] CH_IN_LAST   = 5'd31;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_INPEND = 3;
  localparam int ST_TWRAP  = 4;

  typedef struct packed {
    logic [CH_W-1:0]   chan;
    logic [DATA_W-1:0] data;
  } out_entry_t;

  localparam int ENTRY_W = $bits(out_entry_t);

  function automatic logic is_out_chan(input logic [CH_W-1:0] c);
    return (c >= CH_OUT_FIRST) && (c <= CH_OUT_LAST);
  endfunction

  // The input range runs to the top of the 5-bit space, so only the lower bound matters.
  function automatic logic is_in_chan(input logic [CH_W-1:0] c);
    return c >= CH_IN_FIRST;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Generic valid/ready FIFO; a push into an empty FIFO shows at the head one cycle later.
// A push while full is accepted only if the head pops the same cycle; otherwise it is refused.
module io_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst_l,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop_rdy,
  output logic             o_pop_vld,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_pop_vld = !o_empty;
  assign w_pop     = i_pop_rdy && !o_empty;
  assign w_push    = i_push_vld && (!o_full || w_pop);
  // Head reads zero when empty so stale storage never leaks out after reset.
  assign o_pop_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_channel_bank.sv
// Core-addressable channel bank: status, free-running timer, output channels feeding a FIFO, input channels.
// Reads are combinational with write bypass; input is never backpressured, FIFO overflow drops and flags.
module io_channel_bank
  import io_channel_bank_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 16
) (
  input  logic              clock,
  input  logic              rst_l,
  input  logic [CH_W-1:0]   IO_read_sel,
  output logic [DATA_W-1:0] IO_read_data,
  input  logic [CH_W-1:0]   IO_write_sel,
  input  logic [DATA_W-1:0] IO_write_data,
  input  logic              IO_write_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready
);

  localparam int PW = $clog2(TICK_DIV);

  logic [DATA_W-1:0] r_chan [32];
  logic [DATA_W-1:0] r_timer;
  logic [PW-1:0]     r_presc;
  logic              r_ovf;
  logic              r_inpend;
  logic              r_twrap;

  logic              w_wr_status;
  logic              w_wr_timer;
  logic              w_wr_out;
  logic              w_in_wr;
  logic              w_tick;
  logic              w_wrap;
  logic              w_ovf_set;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  out_entry_t        w_push_dat;
  out_entry_t        w_head;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd;

  assign in_ready    = 1'b1;
  assign w_wr_status = IO_write_en && (IO_write_sel == CH_STATUS);
  assign w_wr_timer  = IO_write_en && (IO_write_sel == CH_TIMER);
  assign w_wr_out    = IO_write_en && is_out_chan(IO_write_sel);
  assign w_in_wr     = in_valid && is_in_chan(in_chan);
  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_wrap      = w_tick && !w_wr_timer && (r_timer == '1);
  // Full with no same-cycle pop is the only case the FIFO refuses the push.
  assign w_ovf_set   = w_wr_out && w_fifo_full && !out_ready;

  assign w_push_dat.chan = IO_write_sel;
  assign w_push_dat.data = IO_write_data;
  assign out_chan        = w_head.chan;
  assign out_data        = w_head.data;

  io_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .rst_l     (rst_l),
    .i_push_vld(w_wr_out),
    .i_push_dat(w_push_dat),
    .i_pop_rdy (out_ready),
    .o_pop_vld (out_valid),
    .o_pop_dat (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_comb begin
    w_status            = '0;
    w_status[ST_FULL]   = w_fifo_full;
    w_status[ST_EMPTY]  = w_fifo_empty;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_INPEND] = r_inpend;
    w_status[ST_TWRAP]  = r_twrap;
  end

  always_comb begin
    w_rd = r_chan[IO_read_sel];
    if (IO_read_sel == CH_STATUS)     w_rd = w_status;
    else if (IO_read_sel == CH_TIMER) w_rd = r_timer;
    // Bypass covers timer and output channels; status and input channels never reflect core writes.
    if (IO_write_en && (IO_write_sel == IO_read_sel) &&
        (IO_read_sel >= CH_TIMER) && (IO_read_sel <= CH_OUT_LAST))
      w_rd = IO_write_data;
    IO_read_data = w_rd;
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 32; i++) r_chan[i] <= '0;
      r_timer  <= '0;
      r_presc  <= '0;
      r_ovf    <= 1'b0;
      r_inpend <= 1'b0;
      r_twrap  <= 1'b0;
    end else begin
      if (w_wr_out) r_chan[IO_write_sel] <= IO_write_data;
      if (w_in_wr)  r_chan[in_chan]      <= in_data;

      if (w_wr_timer) begin
        r_timer <= IO_write_data;
        r_presc <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) r_timer <= r_timer + DATA_W'(1);
      end

      // Sticky bits: W1C clear, with a same-cycle set taking priority.
      r_ovf    <= w_ovf_set | (r_ovf    & ~(w_wr_status & IO_write_data[ST_OVF]));
      r_inpend <= w_in_wr   | (r_inpend & ~(w_wr_status & IO_write_data[ST_INPEND]));
      r_twrap  <= w_wrap    | (r_twrap  & ~(w_wr_status & IO_write_data[ST_TWRAP]));
    end
  end

endmodule

// File: tb/tb_io_channel_bank.sv
// Bench for io_channel_bank: directed scenarios plus randomized traffic against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from that edge.
module tb_io_channel_bank;

  localparam int FIFO_DEPTH = 4;
  localparam int TICK_DIV   = 16;

  logic        clock = 1'b0;
  logic        rst_l;
  logic [4:0]  IO_read_sel, IO_write_sel, in_chan, out_chan;
  logic [14:0] IO_read_data, IO_write_data, in_data, out_data;
  logic        IO_write_en, out_valid, out_ready, in_valid, in_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  io_channel_bank #(.FIFO_DEPTH(FIFO_DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .rst_l(rst_l),
    .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
    .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data), .IO_write_en(IO_write_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data),
    .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data), .in_ready(in_ready)
  );

  task automatic idle();
    IO_write_en = 0; IO_write_sel = 0; IO_write_data = 0; IO_read_sel = 0;
    out_ready = 0; in_valid = 0; in_chan = 0; in_data = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic rd(input logic [4:0] sel);
    IO_read_sel = sel; #1;
  endtask

  task automatic core_write(input logic [4:0] sel, input logic [14:0] dat);
    IO_write_en = 1; IO_write_sel = sel; IO_write_data = dat;
  endtask

  task automatic do_reset();
    idle(); rst_l = 0;
    repeat (2) @(posedge clock);
    #2 rst_l = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    rd(0);
    vectors++; if (IO_read_data !== 15'h0002) begin miscompares++; $display("FAIL reset_ch0 got=%h exp=0002", IO_read_data); end
    rd(1);
    vectors++; if (IO_read_data !== 15'h0000) begin miscompares++; $display("FAIL reset_ch1 got=%h exp=0000", IO_read_data); end
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_flags out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    core_write(5, 15'h0077); step();
    core_write(6, 15'h0066); step();
    idle(); rd(5);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
    #1 rst_l = 0; #1;
    vectors++; if (out_valid !== 1'b0 || out_chan !== 5'd0 || out_data !== 15'd0) begin
      miscompares++; $display("FAIL async_reset_head valid=%b chan=%0d data=%h exp 0/0/0", out_valid, out_chan, out_data); end
    vectors++; if (IO_read_data !== 15'h0000) begin miscompares++; $display("FAIL async_reset_ch5 got=%h exp=0000", IO_read_data); end
    rd(0);
    vectors++; if (IO_read_data !== 15'h0002) begin miscompares++; $display("FAIL async_reset_ch0 got=%h exp=0002", IO_read_data); end
    out_ready = 1;
    repeat (2) @(posedge clock);
    #2 rst_l = 1; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    idle(); step();
  endtask

  task automatic test_write_fifo();
    do_reset();
    core_write(5, 15'h1234); rd(5);
    vectors++; if (IO_read_data !== 15'h1234) begin miscompares++; $display("FAIL bypass_ch5 got=%h exp=1234", IO_read_data); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL push_latency got=%b exp=0", out_valid); end
    step(); IO_write_en = 0; #1;
    vectors++; if (out_valid !== 1'b1 || out_chan !== 5'd5 || out_data !== 15'h1234) begin
      miscompares++; $display("FAIL head_after_push valid=%b chan=%0d data=%h exp 1/5/1234", out_valid, out_chan, out_data); end
    vectors++; if (IO_read_data !== 15'h1234) begin miscompares++; $display("FAIL ch5_reg got=%h exp=1234", IO_read_data); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_chan !== 5'd5 || out_data !== 15'h1234) begin
      miscompares++; $display("FAIL head_stable valid=%b chan=%0d data=%h exp 1/5/1234", out_valid, out_chan, out_data); end
    out_ready = 1; step(); out_ready = 0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pop_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin core_write(2, 15'h0100 + 15'(i)); step(); end
    idle(); rd(0);
    vectors++; if (IO_read_data !== 15'h0005) begin miscompares++; $display("FAIL overflow_status got=%h exp=0005", IO_read_data); end
    rd(2);
    vectors++; if (IO_read_data !== 15'h0104) begin miscompares++; $display("FAIL overflow_ch2 got=%h exp=0104", IO_read_data); end
    core_write(0, 15'h0004); step(); idle(); rd(0);
    vectors++; if (IO_read_data !== 15'h0001) begin miscompares++; $display("FAIL w1c_ovf got=%h exp=0001", IO_read_data); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_chan !== 5'd2 || out_data !== 15'h0100 + 15'(i)) begin
        miscompares++; $display("FAIL drain_%0d valid=%b chan=%0d data=%h exp 1/2/%h", i, out_valid, out_chan, out_data, 15'h0100 + 15'(i)); end
      out_ready = 1; step(); out_ready = 0;
    end
    rd(0);
    vectors++; if (IO_read_data !== 15'h0002) begin miscompares++; $display("FAIL drained_status got=%h exp=0002", IO_read_data); end
  endtask

  task automatic test_full_push_pop();
    logic [19:0] exp_seq [4];
    exp_seq[0] = {5'd2, 15'h00A1}; exp_seq[1] = {5'd2, 15'h00A2};
    exp_seq[2] = {5'd2, 15'h00A3}; exp_seq[3] = {5'd3, 15'h0333};
    do_reset();
    for (int i = 0; i < 4; i++) begin core_write(2, 15'h00A0 + 15'(i)); step(); end
    idle(); rd(0);
    vectors++; if (IO_read_data !== 15'h0001) begin miscompares++; $display("FAIL full_status got=%h exp=0001", IO_read_data); end
    core_write(3, 15'h0333); out_ready = 1; step(); idle(); rd(0);
    vectors++; if (IO_read_data !== 15'h0001) begin miscompares++; $display("FAIL full_push_pop_status got=%h exp=0001", IO_read_data); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp_seq[i]) begin
        miscompares++; $display("FAIL full_push_pop_%0d got=%h exp=%h", i, {out_chan, out_data}, exp_seq[i]); end
      out_ready = 1; step(); out_ready = 0;
    end
  endtask

  task automatic test_timer();
    do_reset();
    core_write(1, 15'h7FFF); rd(1);
    vectors++; if (IO_read_data !== 15'h7FFF) begin miscompares++; $display("FAIL bypass_ch1 got=%h exp=7FFF", IO_read_data); end
    step(); idle();
    repeat (TICK_DIV - 1) step();
    rd(1);
    vectors++; if (IO_read_data !== 15'h7FFF) begin miscompares++; $display("FAIL timer_pre_tick got=%h exp=7FFF", IO_read_data); end
    step(); rd(1);
    vectors++; if (IO_read_data !== 15'h0000) begin miscompares++; $display("FAIL timer_wrap got=%h exp=0000", IO_read_data); end
    rd(0);
    vectors++; if (IO_read_data !== 15'h0012) begin miscompares++; $display("FAIL wrap_status got=%h exp=0012", IO_read_data); end
    core_write(0, 15'h0010); step(); idle(); rd(0);
    vectors++; if (IO_read_data !== 15'h0002) begin miscompares++; $display("FAIL w1c_wrap got=%h exp=0002", IO_read_data); end
    core_write(1, 15'h0100); step(); idle();
    repeat (TICK_DIV - 1) step();
    core_write(1, 15'h0200); step(); idle(); rd(1);
    vectors++; if (IO_read_data !== 15'h0200) begin miscompares++; $display("FAIL load_on_tick got=%h exp=0200", IO_read_data); end
    repeat (TICK_DIV - 1) step();
    rd(1);
    vectors++; if (IO_read_data !== 15'h0200) begin miscompares++; $display("FAIL presc_zeroed got=%h exp=0200", IO_read_data); end
    step(); rd(1);
    vectors++; if (IO_read_data !== 15'h0201) begin miscompares++; $display("FAIL timer_incr got=%h exp=0201", IO_read_data); end
  endtask

  task automatic test_input();
    do_reset();
    core_write(0, 15'h0008); in_valid = 1; in_chan = 20; in_data = 15'h0ABC;
    step(); idle(); rd(20);
    vectors++; if (IO_read_data !== 15'h0ABC) begin miscompares++; $display("FAIL in_ch20 got=%h exp=0ABC", IO_read_data); end
    rd(0);
    vectors++; if (IO_read_data !== 15'h000A) begin miscompares++; $display("FAIL inpend_set_wins got=%h exp=000A", IO_read_data); end
    core_write(20, 15'h1111); rd(20);
    vectors++; if (IO_read_data !== 15'h0ABC) begin miscompares++; $display("FAIL no_bypass_ch20 got=%h exp=0ABC", IO_read_data); end
    step(); idle(); rd(20);
    vectors++; if (IO_read_data !== 15'h0ABC) begin miscompares++; $display("FAIL core_write_ch20 got=%h exp=0ABC", IO_read_data); end
    core_write(0, 15'h0008); step(); idle();
    in_valid = 1; in_chan = 7; in_data = 15'h0555; step();
    in_chan = 0; in_data = 15'h7FFF; step(); idle(); rd(7);
    vectors++; if (IO_read_data !== 15'h0000) begin miscompares++; $display("FAIL in_ch7_ignored got=%h exp=0000", IO_read_data); end
    rd(0);
    vectors++; if (IO_read_data !== 15'h0002) begin miscompares++; $display("FAIL inpend_cleared got=%h exp=0002", IO_read_data); end
  endtask

  task automatic test_random();
    logic [14:0] m_chan [32];
    logic [19:0] m_q [$];
    bit          m_ovf, m_inp, m_wrap;
    int unsigned m_base, m_since, r;
    logic [14:0] exp_rd, m_timer;
    for (int i = 0; i < 32; i++) m_chan[i] = '0;
    m_ovf = 0; m_inp = 0; m_wrap = 0; m_base = 0; m_since = 0;
    idle(); rst_l = 0;
    @(posedge clock); #2 rst_l = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      IO_write_en = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 99);
      if (r < 10)      IO_write_sel = 5'd0;
      else if (r < 15) IO_write_sel = 5'd1;
      else if (r < 80) IO_write_sel = 5'($urandom_range(2, 15));
      else             IO_write_sel = 5'($urandom_range(16, 31));
      IO_write_data = (IO_write_sel == 5'd1) ? 15'h7FFC + 15'($urandom_range(0, 3)) : 15'($urandom());
      IO_read_sel   = ($urandom_range(0, 1) == 1) ? IO_write_sel : 5'($urandom_range(0, 31));
      out_ready     = ($urandom_range(0, 99) < 40);
      in_valid      = ($urandom_range(0, 1) == 1);
      in_chan       = 5'($urandom_range(0, 31));
      in_data       = 15'($urandom());
      @(negedge clock);
      m_timer = 15'((m_base + m_since / TICK_DIV) % 32768);
      if (IO_read_sel == 0)      exp_rd = {10'd0, m_wrap, m_inp, m_ovf, m_q.size() == 0, m_q.size() == FIFO_DEPTH};
      else if (IO_read_sel == 1) exp_rd = m_timer;
      else                       exp_rd = m_chan[IO_read_sel];
      if (IO_write_en && IO_write_sel == IO_read_sel && IO_read_sel >= 1 && IO_read_sel <= 15) exp_rd = IO_write_data;
      vectors++; if (IO_read_data !== exp_rd) begin miscompares++; $display("FAIL rand_read cyc=%0d sel=%0d got=%h exp=%h", cyc, IO_read_sel, IO_read_data, exp_rd); end
      vectors++; if (out_valid !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        vectors++; if ({out_chan, out_data} !== m_q[0]) begin miscompares++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, {out_chan, out_data}, m_q[0]); end
      end
      @(posedge clock);
      if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (IO_write_en && IO_write_sel == 0) begin
        if (IO_write_data[2]) m_ovf = 0;
        if (IO_write_data[3]) m_inp = 0;
        if (IO_write_data[4]) m_wrap = 0;
      end
      if (IO_write_en && IO_write_sel >= 2 && IO_write_sel <= 15) begin
        m_chan[IO_write_sel] = IO_write_data;
        if (m_q.size() < FIFO_DEPTH) m_q.push_back({IO_write_sel, IO_write_data});
        else m_ovf = 1;
      end
      if (in_valid && in_chan >= 16) begin m_chan[in_chan] = in_data; m_inp = 1; end
      if (IO_write_en && IO_write_sel == 1) begin
        m_base = IO_write_data; m_since = 0;
      end else begin
        m_since++;
        if (m_since % TICK_DIV == 0 && (m_base + m_since / TICK_DIV) % 32768 == 0) m_wrap = 1;
      end
      #1;
    end
    idle();
  endtask

  initial begin
    idle(); rst_l = 0;
    test_reset();
    test_write_fifo();
    test_overflow();
    test_full_push_pop();
    test_timer();
    test_input();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_channel_bank.md
IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

Interface
REQ-001 Parameter FIFO_DEPTH, 4, outbound FIFO entries (power of two, >=2).
REQ-002 Parameter TICK_DIV, 16, clock cycles per timer increment (>=2).
REQ-003 clock  input  1  system clock, all state on rising edge.
REQ-004 rst_l  input  1  reset, asynchronous, active-low.
REQ-005 IO_read_sel  input  5  channel read by core.
REQ-006 IO_read_data  output  15  read data for IO_read_sel, combinational.
REQ-007 IO_write_sel  input  5  channel written by core.
REQ-008 IO_write_data  input  15  core write data.
REQ-009 IO_write_en  input  1  core write strobe, one write per asserted cycle.
REQ-010 out_valid  output  1  outbound FIFO head valid.
REQ-011 out_ready  input  1  peripheral accepts head.
REQ-012 out_chan  output  5  channel of FIFO head.
REQ-013 out_data  output  15  data of FIFO head.
REQ-014 in_valid  input  1  peripheral input strobe.
REQ-015 in_chan  input  5  target input channel.
REQ-016 in_data  input  15  input data.
REQ-017 in_ready  output  1  constant 1; the block never backpressures input.

Function
REQ-018 Channel map: 0 status, 1 timer, 2-15 output channels, 16-31 input channels.
REQ-019 Status bits: [0] FIFO full, [1] FIFO empty, [2] overflow sticky, [3] input pending sticky, [4] timer wrap sticky; [14:5] read 0.
REQ-020 Write to ch0 clears each sticky bit (2,3,4) whose data bit is 1 (W1C); other bits ignored.
REQ-021 Sticky set and W1C clear in the same cycle: set wins.
REQ-022 Read is combinational; no read side effects.
REQ-023 Same-cycle bypass: if IO_write_en and IO_write_sel==IO_read_sel and the channel is 1-15, IO_read_data returns IO_write_data.
REQ-024 Timer: prescaler counts 0..TICK_DIV-1; on terminal count, timer increments by 1 mod 2^15.
REQ-025 Timer 0x7FFF->0x0000 wrap sets status[4].
REQ-026 Core write to ch1 loads timer and zeroes prescaler; this write wins over a same-cycle tick.
REQ-027 Core write to ch2-15 updates the channel register and pushes {sel,data} into the FIFO the same cycle.
REQ-028 FIFO: out_valid = not empty; pop on out_valid & out_ready; head outputs are stable while out_valid & !out_ready.
REQ-029 Push when full with a same-cycle pop: both occur, and occupancy stays full.
REQ-030 Push when full without a pop: entry dropped, the channel register is still updated, and status[2] is set.
REQ-031 Pop when empty: no effect; push to empty: out_valid rises the next cycle (1-cycle latency).
REQ-032 in_valid with in_chan 16-31 writes that channel next edge and sets status[3]; in_chan 0-15 is ignored.
REQ-033 Core writes to ch16-31 are ignored.
REQ-034 Core writing ch0 and input arriving the same cycle: REQ-021 applies to status[3].

Reset
REQ-035 rst_l low asynchronously clears all channel registers, timer, prescaler, sticky bits, and FIFO pointers/occupancy.
REQ-036 During reset: out_valid=0, out_chan=0, out_data=0, IO_read_data per cleared state (ch0 reads 0x0002).
REQ-037 Reset mid-transfer discards FIFO contents; no pop completes after reset assertion.

Structure
REQ-038 Channel index constants (CH_STATUS, CH_TIMER, CH_OUT_FIRST/LAST, CH_IN_FIRST/LAST) and status bit positions belong in the shared core package.
REQ-039 Outbound FIFO is one sub-module, io_fifo, parameterised by width (20) and depth.
REQ-040 Core IO ports connect name-for-name to the Core IO_* ports.

Verification
REQ-041 After reset, read ch0 -> 0x0002; read ch1 -> 0; out_valid=0.
REQ-042 Write ch5=0x1234, out_ready=0 -> next cycle out_valid=1, out_chan=5, out_data=0x1234, and same-cycle read ch5 -> 0x1234 (bypass).
REQ-043 Five writes to ch2 with out_ready=0 (depth 4) -> status=0x0005; then write ch0=0x0004 -> status=0x0001.
REQ-044 FIFO full, write ch3 with out_ready=1 same cycle -> status[2] stays 0 and the ch3 entry appears after 3 pops.
REQ-045 Load ch1=0x7FFF, wait TICK_DIV cycles -> timer reads 0, status[4]=1; write ch1 on the terminal tick cycle -> loaded value, no increment.
REQ-046 in_valid, in_chan=20, in_data=0x0ABC, with ch0=0x0008 written same cycle -> ch20 reads 0x0ABC and status[3]=1; in_chan=7 -> ch7 unchanged.
